pci_target_burst: RTL and testbench
===================================

PCI_TARGET_BURST -- requirements
Module: pci_target_burst

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0001_0000, giving the claimed window base; bits [ADDR_WIDTH+1:0] are ignored.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, giving the memory word-address width; depth is 2^ADDR_WIDTH 32-bit words.
REQ-003 SHALL have parameter WAIT_STATES, default 0, range 0..3, giving the initial target latency in clocks before the first TRDY.
REQ-004 SHALL have port CLK, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-005 SHALL have port RST, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port ADDR_DATA, inout, 32 bits: address and data bus, driven only during read data phases and Z otherwise.
REQ-007 SHALL have port C_BE, input, 4 bits: command in the address phase, active-low byte enables in data phases.
REQ-008 SHALL have port FRAME, input, 1 bit: active-low, initiator transaction in progress.
REQ-009 SHALL have port IRDY, input, 1 bit: active-low initiator ready.
REQ-010 SHALL have port TRDY, output, 1 bit: active-low target ready, registered.
REQ-011 SHALL have port DEVSEL, output, 1 bit: active-low device select, registered.
REQ-012 SHALL have port STOP, output, 1 bit: active-low disconnect request, registered.

Function
REQ-013 SHALL implement states IDLE, LATENCY, XFER, DISCONNECT and RELEASE.
REQ-014 SHALL claim a transaction in IDLE when, at edge k, FRAME=0, ADDR_DATA[31:ADDR_WIDTH+2] equals BASE_ADDR[31:ADDR_WIDTH+2], and C_BE is 4'b0110 (mem read) or 4'b0111 (mem write); it SHALL also latch the word address ADDR_DATA[ADDR_WIDTH+1:2] and the direction.
REQ-015 SHALL remain in IDLE with all outputs deasserted for any other command or on an address mismatch.
REQ-016 SHALL drive DEVSEL=0 after claim edge k and hold it until RELEASE.
REQ-017 SHALL count latency as follows: writes assert TRDY=0 after edge k+WAIT_STATES; reads drive ADDR_DATA and TRDY=0 after edge k+1+WAIT_STATES (one turnaround cycle).
REQ-018 SHALL complete a data phase on every edge where IRDY=0 and TRDY=0 in XFER.
REQ-019 SHALL, on a completed write phase, write each byte lane i of mem[addr] only when C_BE[i]=0.
REQ-020 SHALL, on a completed read phase, present mem[addr+1] after the same edge, with zero wait states within a burst.
REQ-021 SHALL increment the address by 1 after each completed phase.
REQ-022 SHALL, while IRDY=1 in XFER, hold TRDY=0, the address and the read data, and write nothing.
REQ-023 SHALL treat a completed phase sampled with FRAME=1 as the final phase and then go to RELEASE.
REQ-024 SHALL, in RELEASE, drive TRDY=1, DEVSEL=1 and STOP=1, tristate ADDR_DATA, and return to IDLE on the next edge.
REQ-025 SHALL NOT wrap the address: when a phase completes at word 2^ADDR_WIDTH-1 with FRAME=0, it SHALL enter DISCONNECT with TRDY=1, STOP=0 and DEVSEL=0.
REQ-026 SHALL hold DISCONNECT until FRAME is sampled 1, then go to RELEASE.
REQ-027 SHALL tristate ADDR_DATA in DISCONNECT.
REQ-028 SHALL, if FRAME=1 is sampled in LATENCY (initiator abandons before any data), go to RELEASE with no memory write.
REQ-029 SHALL ignore back-to-back address phases while not in IDLE; a new claim is possible only from IDLE.
REQ-030 SHALL, for a single-phase transfer (FRAME=1 at the first completing edge), transfer exactly one word.

Reset
REQ-031 SHALL, on RST=1 at any edge including mid-burst, set state to IDLE, TRDY=1, DEVSEL=1 and STOP=1, and release ADDR_DATA to Z after that edge.
REQ-032 SHALL abort any in-progress phase on reset without writing it.
REQ-033 SHALL NOT reset memory contents.

Verification
REQ-034 SHALL cover a single write: mem write at 32'h0001_0010, data 32'hDEAD_BEEF, C_BE=0000, WAIT_STATES=0 -> TRDY=0 in the cycle after the address; mem[4]=32'hDEAD_BEEF.
REQ-035 SHALL cover a 4-word read burst from 32'h0001_0010 -> DEVSEL=0 after the address, TRDY=0 one cycle later, data mem[4..7] on consecutive cycles; RELEASE then IDLE.
REQ-036 SHALL cover byte enables: write 32'h1122_3344 with C_BE=1010 over an old value of 32'hFFFF_FFFF -> mem=32'hFF22_FF44.
REQ-037 SHALL cover initiator wait: IRDY=1 for 2 cycles mid read burst -> data and address held, no skipped or duplicated word.
REQ-038 SHALL cover end of window: burst write starting at word 254 with FRAME held low -> words 254 and 255 written, then STOP=0 and TRDY=1 until FRAME=1, then all outputs released.
REQ-039 SHALL cover reset and mismatch: address 32'h0002_0000 -> no DEVSEL; RST=1 mid-burst -> outputs high and bus Z next cycle, and the next claim succeeds normally.

Source files
------------

// File: rtl/pci_target_burst.sv
// PCI target claiming a memory window backed by a 2^ADDR_WIDTH x 32 RAM, supporting burst reads/writes.
// Latency: DEVSEL one clock after claim, first TRDY after WAIT_STATES (+1 turnaround on reads), then zero-wait bursts.
// Backpressure: IRDY high stalls the current phase; reaching the last word forces a STOP disconnect.
module pci_target_burst #(
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
    parameter int          ADDR_WIDTH  = 8,
    parameter int          WAIT_STATES = 0
) (
    input  logic        CLK,
    input  logic        RST,
    inout  wire  [31:0] ADDR_DATA,
    input  logic [3:0]  C_BE,
    input  logic        FRAME,
    input  logic        IRDY,
    output logic        TRDY,
    output logic        DEVSEL,
    output logic        STOP
);

    localparam logic [3:0]            CMD_MEM_RD = 4'b0110;
    localparam logic [3:0]            CMD_MEM_WR = 4'b0111;
    localparam logic [2:0]            RD_LAT     = 3'(WAIT_STATES + 1);
    localparam logic [2:0]            WR_LAT     = 3'(WAIT_STATES);
    localparam logic [ADDR_WIDTH-1:0] LAST_WORD  = {ADDR_WIDTH{1'b1}};

    typedef enum logic [2:0] {
        IDLE,
        LATENCY,
        XFER,
        DISCONNECT,
        RELEASE
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  is_rd_q, is_rd_d;
    logic [2:0]            lat_q, lat_d;
    logic                  trdy_q, devsel_q, stop_q, drive_q;
    logic                  trdy_d, devsel_d, stop_d, drive_d;
    logic                  mem_we;
    logic                  claim;
    logic                  cmd_rd, cmd_wr;
    logic [2:0]            first_lat;

    logic [31:0] mem [0:(1 << ADDR_WIDTH) - 1];

    assign cmd_rd    = (C_BE == CMD_MEM_RD);
    assign cmd_wr    = (C_BE == CMD_MEM_WR);
    assign claim     = !FRAME && (cmd_rd || cmd_wr) &&
                       (ADDR_DATA[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
    assign first_lat = cmd_rd ? RD_LAT : WR_LAT;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        is_rd_d = is_rd_q;
        lat_d   = lat_q;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (claim) begin
                    is_rd_d = cmd_rd;
                    addr_d  = ADDR_DATA[ADDR_WIDTH+1:2];
                    lat_d   = first_lat;
                    state_d = (first_lat == 3'd0) ? XFER : LATENCY;
                end
            end
            LATENCY: begin
                if (FRAME) begin
                    state_d = RELEASE;
                end else if (lat_q <= 3'd1) begin
                    state_d = XFER;
                end else begin
                    lat_d = lat_q - 3'd1;
                end
            end
            XFER: begin
                // TRDY is always low in XFER, so IRDY alone completes a phase
                if (!IRDY) begin
                    mem_we = !is_rd_q;
                    if (addr_q != LAST_WORD) begin
                        addr_d = addr_q + 1'b1;
                    end
                    if (FRAME) begin
                        state_d = RELEASE;
                    end else if (addr_q == LAST_WORD) begin
                        state_d = DISCONNECT;
                    end
                end
            end
            DISCONNECT: begin
                if (FRAME) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they change exactly on the edge
    always_comb begin
        trdy_d   = (state_d != XFER);
        devsel_d = !((state_d == LATENCY) || (state_d == XFER) || (state_d == DISCONNECT));
        stop_d   = (state_d != DISCONNECT);
        drive_d  = (state_d == XFER) && is_rd_d;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            is_rd_q  <= 1'b0;
            lat_q    <= '0;
            trdy_q   <= 1'b1;
            devsel_q <= 1'b1;
            stop_q   <= 1'b1;
            drive_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            is_rd_q  <= is_rd_d;
            lat_q    <= lat_d;
            trdy_q   <= trdy_d;
            devsel_q <= devsel_d;
            stop_q   <= stop_d;
            drive_q  <= drive_d;
        end
    end

    // Memory contents survive reset; a phase coinciding with reset is dropped
    always_ff @(posedge CLK) begin
        if (mem_we && !RST) begin
            for (int i = 0; i < 4; i++) begin
                if (!C_BE[i]) begin
                    mem[addr_q][8*i +: 8] <= ADDR_DATA[8*i +: 8];
                end
            end
        end
    end

    assign ADDR_DATA = drive_q ? mem[addr_q] : 'z;
    assign TRDY      = trdy_q;
    assign DEVSEL    = devsel_q;
    assign STOP      = stop_q;

endmodule

// File: tb/tb_pci_target_burst.sv
// Randomized bench for pci_target_burst against a word-array memory model with per-phase bus timing rules.
module tb_pci_target_burst;

    localparam logic [31:0] BASE  = 32'h0001_0000;
    localparam int          DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst;
    wire  [31:0] ad;
    logic [31:0] tb_ad;
    logic        tb_oe;
    logic [3:0]  cbe;
    logic        frame, irdy;
    logic        trdy, devsel, stop;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] ref_mem [DEPTH];
    logic [31:0] wdat_q [$];

    assign ad = tb_oe ? tb_ad : 'z;
    for (genvar gi = 0; gi < 32; gi++) begin : g_pu
        pullup (ad[gi]);
    end

    always #5 clk = ~clk;

    pci_target_burst #(
        .BASE_ADDR  (BASE),
        .ADDR_WIDTH (8),
        .WAIT_STATES(0)
    ) dut (
        .CLK      (clk),
        .RST      (rst),
        .ADDR_DATA(ad),
        .C_BE     (cbe),
        .FRAME    (frame),
        .IRDY     (irdy),
        .TRDY     (trdy),
        .DEVSEL   (devsel),
        .STOP     (stop)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic t, input logic d, input logic s);
        check_eq({tag, "_trdy"},   32'(trdy),   32'(t));
        check_eq({tag, "_devsel"}, 32'(devsel), 32'(d));
        check_eq({tag, "_stop"},   32'(stop),   32'(s));
    endtask

    // Released bus floats to the pull-up value
    task automatic check_bus_free(input string tag);
        check_eq({tag, "_busz"}, ad, 32'hFFFF_FFFF);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle;
        frame = 1'b1;
        irdy  = 1'b1;
        tb_oe = 1'b0;
        cbe   = 4'hF;
    endtask

    task automatic finish_disconnect(input string tag);
        check_outs({tag, "_disc"}, 1'b1, 1'b0, 1'b0);
        irdy  = 1'b1;
        frame = 1'b0;
        tb_oe = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick;
            check_outs({tag, "_dischold"}, 1'b1, 1'b0, 1'b0);
            check_bus_free({tag, "_dischold"});
        end
        go_idle;
        tick;
        check_outs({tag, "_discrel"}, 1'b1, 1'b1, 1'b1);
        tick;
        check_outs({tag, "_discidle"}, 1'b1, 1'b1, 1'b1);
    endtask

    // be_sel < 0 gives random byte enables; data comes from wdat_q, else random
    task automatic wr_burst(input int start, input int n, input bit rand_wait, input int be_sel);
        int          a;
        int          w;
        logic [31:0] d;
        logic [3:0]  be;
        a     = start;
        frame = 1'b0;
        irdy  = 1'b1;
        tb_oe = 1'b1;
        tb_ad = BASE + 32'(start << 2);
        cbe   = 4'b0111;
        tick;
        check_outs("wr_claim", 1'b0, 1'b0, 1'b1);
        for (int j = 0; j < n; j++) begin
            d  = (wdat_q.size() > 0) ? wdat_q.pop_front() : $urandom;
            be = (be_sel < 0) ? 4'($urandom) : 4'(be_sel);
            w  = rand_wait ? int'($urandom_range(0, 2)) : 0;
            tb_ad = d;
            cbe   = be;
            for (int i = 0; i < w; i++) begin
                irdy  = 1'b1;
                frame = 1'b0;
                tick;
                check_outs("wr_wait", 1'b0, 1'b0, 1'b1);
            end
            irdy  = 1'b0;
            frame = (j == n - 1);
            tick;
            for (int b = 0; b < 4; b++) begin
                if (!be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
            end
            if (j == n - 1) begin
                check_outs("wr_rel", 1'b1, 1'b1, 1'b1);
                go_idle;
                tick;
                check_outs("wr_idle", 1'b1, 1'b1, 1'b1);
                break;
            end
            if (a == DEPTH - 1) begin
                finish_disconnect("wr");
                break;
            end
            a++;
            check_outs("wr_xfer", 1'b0, 1'b0, 1'b1);
        end
        wdat_q.delete();
    endtask

    task automatic rd_burst(input int start, input int n, input bit rand_wait, input int wait_at);
        int a;
        int w;
        a     = start;
        frame = 1'b0;
        irdy  = 1'b1;
        tb_oe = 1'b1;
        tb_ad = BASE + 32'(start << 2);
        cbe   = 4'b0110;
        tick;
        check_outs("rd_claim", 1'b1, 1'b0, 1'b1);
        tb_oe = 1'b0;
        cbe   = 4'b0000;
        tick;
        for (int j = 0; j < n; j++) begin
            check_outs("rd_xfer", 1'b0, 1'b0, 1'b1);
            check_eq("rd_dat", ad, ref_mem[a]);
            w = rand_wait ? int'($urandom_range(0, 2)) : ((j == wait_at) ? 2 : 0);
            for (int i = 0; i < w; i++) begin
                irdy  = 1'b1;
                frame = 1'b0;
                tick;
                check_eq("rd_wait_trdy", 32'(trdy), 32'd0);
                check_eq("rd_wait_dat", ad, ref_mem[a]);
            end
            irdy  = 1'b0;
            frame = (j == n - 1);
            tick;
            if (j == n - 1) begin
                check_outs("rd_rel", 1'b1, 1'b1, 1'b1);
                check_bus_free("rd_rel");
                go_idle;
                tick;
                check_outs("rd_idle", 1'b1, 1'b1, 1'b1);
                break;
            end
            if (a == DEPTH - 1) begin
                finish_disconnect("rd");
                break;
            end
            a++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst   = 1'b1;
        tb_ad = '0;
        go_idle;
        tick;
        tick;
        check_outs("reset", 1'b1, 1'b1, 1'b1);
        check_bus_free("reset");
        rst = 1'b0;
        tick;

        // Fill the whole window; runs off the end and gets disconnected
        wr_burst(0, 260, 1'b0, 0);

        // Single write at 0x0001_0010 then 4-word read burst
        wdat_q.push_back(32'hDEAD_BEEF);
        wr_burst(4, 1, 1'b0, 0);
        rd_burst(4, 4, 1'b0, -1);

        // Byte enables over an all-ones word
        wdat_q.push_back(32'hFFFF_FFFF);
        wr_burst(30, 1, 1'b0, 0);
        wdat_q.push_back(32'h1122_3344);
        wr_burst(30, 1, 1'b0, 4'b1010);
        rd_burst(30, 1, 1'b0, -1);

        // Initiator wait mid read burst
        rd_burst(40, 5, 1'b0, 2);

        // End of window: write and read crossing the last word
        wr_burst(254, 4, 1'b0, 0);
        rd_burst(253, 3, 1'b0, -1);
        rd_burst(254, 5, 1'b0, -1);

        // Address mismatch and non-memory command are ignored
        frame = 1'b0;
        irdy  = 1'b1;
        tb_oe = 1'b1;
        tb_ad = 32'h0002_0000;
        cbe   = 4'b0111;
        tick;
        check_outs("mismatch", 1'b1, 1'b1, 1'b1);
        tb_ad = 32'hCAFE_0000;
        cbe   = 4'b0000;
        irdy  = 1'b0;
        tick;
        check_outs("mismatch_dat", 1'b1, 1'b1, 1'b1);
        go_idle;
        tick;
        frame = 1'b0;
        tb_oe = 1'b1;
        tb_ad = BASE + 32'h20;
        cbe   = 4'b0010;
        tick;
        check_outs("badcmd", 1'b1, 1'b1, 1'b1);
        go_idle;
        tick;

        // Initiator abandons during read turnaround
        frame = 1'b0;
        tb_oe = 1'b1;
        tb_ad = BASE + 32'h40;
        cbe   = 4'b0110;
        tick;
        check_outs("abandon_claim", 1'b1, 1'b0, 1'b1);
        go_idle;
        tick;
        check_outs("abandon_rel", 1'b1, 1'b1, 1'b1);
        check_bus_free("abandon_rel");
        tick;

        // Reset mid read burst while the target drives the bus
        frame = 1'b0;
        tb_oe = 1'b1;
        tb_ad = BASE + 32'(10 << 2);
        cbe   = 4'b0110;
        tick;
        tb_oe = 1'b0;
        cbe   = 4'b0000;
        tick;
        check_eq("rstrd_dat", ad, ref_mem[10]);
        irdy = 1'b0;
        tick;
        check_eq("rstrd_dat2", ad, ref_mem[11]);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        go_idle;
        check_outs("rstrd", 1'b1, 1'b1, 1'b1);
        check_bus_free("rstrd");
        tick;
        check_outs("rstrd_idle", 1'b1, 1'b1, 1'b1);

        // Reset coinciding with a write phase: nothing written
        frame = 1'b0;
        tb_oe = 1'b1;
        tb_ad = BASE + 32'(20 << 2);
        cbe   = 4'b0111;
        tick;
        tb_ad = ~ref_mem[20];
        cbe   = 4'b0000;
        irdy  = 1'b0;
        rst   = 1'b1;
        tick;
        rst = 1'b0;
        go_idle;
        check_outs("rstwr", 1'b1, 1'b1, 1'b1);
        tick;
        rd_burst(20, 1, 1'b0, -1);

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            int start;
            int n;
            start = ($urandom_range(0, 3) == 0) ? int'($urandom_range(248, 255))
                                                : int'($urandom_range(0, 255));
            n = int'($urandom_range(1, 6));
            if ($urandom_range(0, 1) == 1) begin
                wr_burst(start, n, 1'b1, -1);
            end else begin
                rd_burst(start, n, 1'b1, -1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
